// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-stage access controller sitting between the EX/MEM and MEM/WB
// pipeline registers. Accepts one op per handshake. Non-memory ops (and
// misaligned memory ops) are forwarded to MEM/WB on the following cycle.
// Aligned loads and stores are issued on a req/ack data-memory port. Stores
// get byte enables and lane replication. Loads get lane selection and sign or
// zero extension. An access that sees no ack within TIMEOUT wait cycles is
// aborted.
//
// Parameters:
//   DATA_W   data/address width (only 32 is supported)
//   TIMEOUT  wait cycles without mem_ack before an access is aborted (1..255)
//
// Ports:
//   clock, clear         rising-edge clock, asynchronous active-low reset
//   valid_in             EX/MEM presents an op
//   mem_read_in          op is a load (wins over mem_write_in)
//   mem_write_in         op is a store
//   size_in              00 byte, 01 half, 1x word
//   unsigned_in          zero-extend loads
//   addr_in              byte address
//   store_data_in        right-aligned store data
//   alu_result_in        ALU result to forward
//   stall                upstream holds EX/MEM while high
//   mem_req/we/addr/be/wdata  registered memory request, held until ack
//   mem_rdata, mem_ack   read data and one-cycle completion
//   alu_result_out       forwarded ALU result
//   load_data_out        extended load data (0 for stores/non-mem/errors)
//   wb_write             one-cycle MEM/WB write strobe
//   misaligned_err       sticky: a misaligned memory op was seen
//   timeout_err          sticky: an access was aborted by timeout
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        size_in,
    input  logic              unsigned_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] load_data_out,
    output logic              wb_write,
    output logic              misaligned_err,
    output logic              timeout_err
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Lane helpers
    // -----------------------------------------------------------------------
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~lo[0];
            default: is_aligned = (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   calc_be = 4'b0001 << lo;
            2'b01:   calc_be = lo[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] calc_wdata(input logic [1:0]        size,
                                                     input logic [DATA_W-1:0] sd);
        case (size)
            2'b00:   calc_wdata = {4{sd[7:0]}};
            2'b01:   calc_wdata = {2{sd[15:0]}};
            default: calc_wdata = sd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend. Only aligned
    // accesses reach here, so a halfword shift is always 0 or 16.
    function automatic logic signed [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] rdata,
                                                             input logic [1:0]        lo,
                                                             input logic [1:0]        size,
                                                             input logic              uns);
        logic [DATA_W-1:0] lane;
        logic              fill;
        lane = rdata >> {lo, 3'b000};
        case (size)
            2'b00: begin
                fill        = ~uns & lane[7];
                extend_load = {{(DATA_W-8){fill}}, lane[7:0]};
            end
            2'b01: begin
                fill        = ~uns & lane[15];
                extend_load = {{(DATA_W-16){fill}}, lane[15:0]};
            end
            default: begin
                fill        = 1'b0;
                extend_load = rdata;
            end
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [DATA_W-1:0] mem_addr_q,   mem_addr_d;
    logic [3:0]        mem_be_q,     mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] alu_q,        alu_d;
    logic [DATA_W-1:0] load_data_q,  load_data_d;
    logic              wb_write_q,   wb_write_d;
    logic              mis_err_q,    mis_err_d;
    logic              to_err_q,     to_err_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [1:0]        size_q,       size_d;
    logic [1:0]        lo_q,         lo_d;
    logic              uns_q,        uns_d;
    logic              is_load_q,    is_load_d;

    // -----------------------------------------------------------------------
    // Request decode (combinational, in front of the stage register)
    // -----------------------------------------------------------------------
    logic take_op;
    logic is_mem;
    logic aligned;
    logic issue_mem;

    always_comb begin
        take_op   = (state_q == S_IDLE) & valid_in;
        is_mem    = mem_read_in | mem_write_in;
        aligned   = is_aligned(size_in, addr_in[1:0]);
        issue_mem = take_op & is_mem & aligned;
    end

    // DONE releases upstream: the op still presented during DONE is the one
    // just completed, and it is retired at the DONE edge without re-issue.
    // Reset forces stall low even while an op is being presented.
    assign stall = clear & ((state_q == S_WAIT) | issue_mem);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        alu_d       = alu_q;
        load_data_d = load_data_q;
        wb_write_d  = 1'b0;
        mis_err_d   = mis_err_q;
        to_err_d    = to_err_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        lo_d        = lo_q;
        uns_d       = uns_q;
        is_load_d   = is_load_q;

        case (state_q)
            S_IDLE: begin
                if (issue_mem) begin
                    state_d     = S_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~mem_read_in;
                    mem_addr_d  = {addr_in[DATA_W-1:2], 2'b00};
                    mem_be_d    = calc_be(size_in, addr_in[1:0]);
                    mem_wdata_d = calc_wdata(size_in, store_data_in);
                    alu_d       = alu_result_in;
                    load_data_d = '0;
                    size_d      = size_in;
                    lo_d        = addr_in[1:0];
                    uns_d       = unsigned_in;
                    is_load_d   = mem_read_in;
                    // Counts the wait cycle being entered, so the abort
                    // happens at the end of wait cycle number TIMEOUT.
                    cnt_d       = CNT_W'(1);
                end else if (take_op) begin
                    // Non-memory op, or misaligned access that is dropped.
                    alu_d       = alu_result_in;
                    load_data_d = '0;
                    wb_write_d  = 1'b1;
                    if (is_mem) begin
                        mis_err_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (mem_ack) begin
                    // Ack wins over a timeout in the same cycle.
                    state_d     = S_DONE;
                    wb_write_d  = 1'b1;
                    load_data_d = is_load_q ? extend_load(mem_rdata, lo_q, size_q, uns_q) : '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = S_DONE;
                    wb_write_d  = 1'b1;
                    load_data_d = '0;
                    to_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (mem_ack || (cnt_q == CNT_W'(TIMEOUT))) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage register (towards MEM/WB and the memory port)
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            alu_q       <= '0;
            load_data_q <= '0;
            wb_write_q  <= 1'b0;
            mis_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
            cnt_q       <= '0;
            size_q      <= '0;
            lo_q        <= '0;
            uns_q       <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            alu_q       <= alu_d;
            load_data_q <= load_data_d;
            wb_write_q  <= wb_write_d;
            mis_err_q   <= mis_err_d;
            to_err_q    <= to_err_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            lo_q        <= lo_d;
            uns_q       <= uns_d;
            is_load_q   <= is_load_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign alu_result_out = alu_q;
    assign load_data_out  = load_data_q;
    assign wb_write       = wb_write_q;
    assign misaligned_err = mis_err_q;
    assign timeout_err    = to_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Bench for mem_access_stage with TIMEOUT=4. A transaction-level model
// (byte counts, lane arithmetic, queue of expected write-backs, sticky error
// bits) predicts the outputs. One compare process checks the DUT every
// falling edge. Directed ops pin key values with literals. Random ops
// follow them.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clock;
    logic        clear;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  size_in;
    logic        unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [31:0] alu_result_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] alu_result_out;
    logic [31:0] load_data_out;
    logic        wb_write;
    logic        misaligned_err;
    logic        timeout_err;

    mem_access_stage #(.DATA_W(32), .TIMEOUT(TMO)) dut (
        .clock          (clock),
        .clear          (clear),
        .valid_in       (valid_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .size_in        (size_in),
        .unsigned_in    (unsigned_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .alu_result_in  (alu_result_in),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .alu_result_out (alu_result_out),
        .load_data_out  (load_data_out),
        .wb_write       (wb_write),
        .misaligned_err (misaligned_err),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] alu;
        logic [31:0] ld;
    } wb_rec_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    wb_rec_t     wbq[$];
    bit          exp_req = 1'b0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    bit          exp_we;
    bit          m_mis = 1'b0;
    bit          m_to  = 1'b0;

    int          wb_cnt  = 0;
    int          req_cyc = 0;
    logic [31:0] last_alu, last_ld, last_addr, last_wdata;
    logic [3:0]  last_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: access geometry from byte counts and lane arithmetic
    // ------------------------------------------------------------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int         off;
        int         nb;
        off = int'(a[1:0]);
        nb  = nbytes(sz);
        be  = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nb) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] w;
        int          nb;
        nb = nbytes(sz);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = sd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input bit uns);
        longint v;
        longint span;
        int     nb;
        nb   = nbytes(sz);
        span = longint'(1) << (8 * nb);
        v    = longint'(rd >> (8 * int'(a[1:0]))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clock) begin : cmp
        wb_rec_t r;
        if (chk_en) begin
            chk("wb_write", {31'd0, wb_write}, {31'd0, wbq.size() > 0});
            if (wbq.size() > 0) begin
                r = wbq.pop_front();
                if (wb_write) begin
                    chk("alu_result_out", alu_result_out, r.alu);
                    chk("load_data_out", load_data_out, r.ld);
                end
            end
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (mem_req && exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            end
            chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, m_mis});
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
        end
        if (wb_write) begin
            wb_cnt++;
            last_alu = alu_result_out;
            last_ld  = load_data_out;
        end
        if (mem_req) begin
            req_cyc++;
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (entered and left 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in      = 1'b0;
            mem_read_in   = 1'($urandom);
            mem_write_in  = 1'($urandom);
            size_in       = 2'($urandom_range(0, 3));
            addr_in       = $urandom;
            store_data_in = $urandom;
            alu_result_in = $urandom;
            mem_ack       = 1'($urandom);
            mem_rdata     = $urandom;
            @(negedge clock);
            chk("stall_idle", {31'd0, stall}, 32'd0);
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
    endtask

    // ack_cyc: wait cycle (1-based) carrying mem_ack; 0 or > TMO = never.
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] alu, input int ack_cyc,
                          input logic [31:0] rdata);
        bit is_mem;
        bit al;
        bit done;
        bit timed;
        int k;
        is_mem        = rd | wr;
        al            = model_aligned(sz, a);
        valid_in      = 1'b1;
        mem_read_in   = rd;
        mem_write_in  = wr;
        size_in       = sz;
        unsigned_in   = uns;
        addr_in       = a;
        store_data_in = sd;
        alu_result_in = alu;
        mem_ack       = 1'b0;
        @(negedge clock);
        chk("stall_accept", {31'd0, stall}, {31'd0, is_mem && al});
        @(posedge clock); #1;
        if (!(is_mem && al)) begin
            wbq.push_back('{alu: alu, ld: 32'd0});
            if (is_mem) m_mis = 1'b1;
            valid_in = 1'b0;
            return;
        end
        exp_req   = 1'b1;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = model_be(sz, a);
        exp_wdata = model_wdata(sz, sd);
        exp_we    = !rd;
        k     = 1;
        done  = 1'b0;
        timed = 1'b0;
        while (!done) begin
            mem_ack   = (k == ack_cyc);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clock);
            chk("stall_wait", {31'd0, stall}, 32'd1);
            @(posedge clock); #1;
            if (mem_ack) done = 1'b1;
            else if (k == TMO) begin
                done  = 1'b1;
                timed = 1'b1;
            end
            mem_ack = 1'b0;
            k++;
        end
        exp_req = 1'b0;
        wbq.push_back('{alu: alu, ld: (rd && !timed) ? model_load(rdata, a, sz, uns) : 32'd0});
        if (timed) m_to = 1'b1;
        @(negedge clock);
        chk("stall_done", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        valid_in = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int w0;
    int r0;

    initial begin
        clear = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        size_in = 2'd0; unsigned_in = 1'b0; addr_in = '0; store_data_in = '0;
        alu_result_in = '0; mem_rdata = '0; mem_ack = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        valid_in = 1'b1; mem_read_in = 1'b1; size_in = 2'd2; addr_in = 32'h0;
        #2;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_wb_write", {31'd0, wb_write}, 32'd0);
        chk("reset_mis_err", {31'd0, misaligned_err}, 32'd0);
        chk("reset_to_err", {31'd0, timeout_err}, 32'd0);
        chk("reset_alu_out", alu_result_out, 32'd0);
        chk("reset_load_out", load_data_out, 32'd0);
        valid_in = 1'b0; mem_read_in = 1'b0;
        @(posedge clock); #1;
        clear  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Non-memory op
        w0 = wb_cnt;
        run_op(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h12345678, 0, 32'h0);
        idle(1);
        chk("nm_alu", last_alu, 32'h12345678);
        chk("nm_load", last_ld, 32'h0);
        chk("nm_wb_count", wb_cnt - w0, 1);

        // Three back-to-back non-memory ops
        w0 = wb_cnt;
        run_op(0, 0, 2'd0, 0, $urandom, $urandom, 32'hA0000001, 0, 32'h0);
        run_op(0, 0, 2'd1, 0, $urandom, $urandom, 32'hA0000002, 0, 32'h0);
        run_op(0, 0, 2'd2, 0, $urandom, $urandom, 32'hA0000003, 0, 32'h0);
        idle(1);
        chk("b2b_wb_count", wb_cnt - w0, 3);

        // Load word, ack on the third wait cycle
        w0 = wb_cnt; r0 = req_cyc;
        run_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h55, 3, 32'hDEADBEEF);
        idle(1);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", {28'd0, last_be}, 32'hF);
        chk("lw_load", last_ld, 32'hDEADBEEF);
        chk("lw_req_cycles", req_cyc - r0, 3);
        chk("lw_wb_count", wb_cnt - w0, 1);

        // Byte loads from lane 3
        run_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h1, 2, 32'h80FFFFFF);
        idle(1);
        chk("lb_signed", last_ld, 32'hFFFFFF80);
        run_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h2, 1, 32'h80FFFFFF);
        idle(1);
        chk("lbu", last_ld, 32'h00000080);

        // Halfword store to upper half
        run_op(0, 1, 2'd1, 0, 32'h102, 32'h0000ABCD, 32'h3, 1, 32'h0);
        idle(1);
        chk("sh_be", {28'd0, last_be}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_load", last_ld, 32'h0);

        // Ack on the final wait cycle beats the timeout
        r0 = req_cyc;
        run_op(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h4, TMO, 32'h0BADF00D);
        idle(1);
        chk("ack_last_req_cycles", req_cyc - r0, TMO);
        chk("ack_last_load", last_ld, 32'h0BADF00D);
        chk("ack_last_no_to_err", {31'd0, timeout_err}, 32'd0);

        // Timeout
        w0 = wb_cnt; r0 = req_cyc;
        run_op(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h5, 0, 32'h0);
        idle(1);
        chk("to_req_cycles", req_cyc - r0, TMO);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_wb_count", wb_cnt - w0, 1);
        chk("to_load", last_ld, 32'h0);

        // Misaligned word load
        w0 = wb_cnt; r0 = req_cyc;
        run_op(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h6, 1, 32'hFFFFFFFF);
        idle(1);
        chk("mis_req_cycles", req_cyc - r0, 0);
        chk("mis_err", {31'd0, misaligned_err}, 32'd1);
        chk("mis_wb_count", wb_cnt - w0, 1);
        chk("mis_load", last_ld, 32'h0);

        // Random ops
        for (int n = 0; n < 300; n++) begin
            int kind;
            bit rd, wr;
            kind = $urandom_range(0, 3);
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            run_op(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                   $urandom, $urandom_range(0, TMO + 1), $urandom);
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a wait
        chk_en = 1'b0;
        w0 = wb_cnt;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; size_in = 2'd2;
        addr_in = 32'h200; mem_ack = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        chk("rst_pre_errs", {31'd0, misaligned_err & timeout_err}, 32'd1);
        #2 clear = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_wb", {31'd0, wb_write}, 32'd0);
        chk("rst_mid_mis", {31'd0, misaligned_err}, 32'd0);
        chk("rst_mid_to", {31'd0, timeout_err}, 32'd0);
        valid_in = 1'b0; mem_read_in = 1'b0;
        wbq.delete();
        exp_req = 1'b0; m_mis = 1'b0; m_to = 1'b0;
        @(posedge clock); #1;
        clear  = 1'b1;
        chk_en = 1'b1;
        idle(4);
        chk("rst_no_wb", wb_cnt - w0, 0);

        // Recovery after reset
        run_op(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h77, 0, 32'h0);
        run_op(1, 0, 2'd1, 0, 32'h302, 32'h0, 32'h88, 2, 32'h8001_1234);
        idle(1);
        chk("post_rst_lh", last_ld, 32'hFFFF8001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
